icb_slave_regs: RTL

ICB slave peripheral: a bank of 32-bit control/status registers addressed over the ICB command channel, answering every command on the response channel. It is the responder end of the ICB link and sits behind the CPU bus decoder, with register contents exposed as flat outputs to the datapath blocks it configures. A 2-entry response buffer decouples command acceptance from CPU response back-pressure, so the block sustains one command per cycle.

---
 rtl/icb_slave_regs_if.sv | 26 ++
 rtl/icb_slave_regs.sv | 128 ++++++++++++
 2 files changed

// File: rtl/icb_slave_regs_if.sv
// ICB command/response link between a CPU-side master and a register slave.
// Ports: icb_cmd_{valid,ready,addr,read,wdata,wmask}, icb_rsp_{valid,ready,rdata,err}.
interface icb_slave_regs_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
        output icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read,
        input  icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/icb_slave_regs.sv
// ICB slave register bank: NUM_REGS x 32-bit regs (reg 0 = read-only ID),
// 2-entry in-order response buffer for one command per cycle.
// Ports: clk, rst_n (async, active-low), icb (slave modport),
//        regs_o (flat register contents), wr_pulse_o (per-register write strobe).
module icb_slave_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ID_VALUE  = 32'h4D45_4C01
) (
    input  logic                   clk,
    input  logic                   rst_n,
    icb_slave_regs_if.slave        icb,
    output logic [NUM_REGS*32-1:0] regs_o,
    output logic [NUM_REGS-1:0]    wr_pulse_o
);

    logic [31:0]         regs_q [1:NUM_REGS-1];
    logic [31:0]         offset;
    logic [5:0]          idx;
    logic                hit;
    logic                accept;
    logic                pop;
    logic                wr_ok;
    logic                rsp_err_d;
    logic [31:0]         rsp_data_d;
    logic [31:0]         rd_val;
    logic [NUM_REGS-1:0] sel;

    logic [1:0]          count_q;
    logic                head_q;
    logic                tail_q;
    logic [31:0]         buf_data_q [2];
    logic                buf_err_q  [2];

    // Offset wraps, so addresses below BASE_ADDR land far out of range.
    assign offset = icb.icb_cmd_addr - BASE_ADDR;
    assign idx    = offset[7:2];
    assign hit    = (icb.icb_cmd_addr[1:0] == 2'b00)
                 && (offset < 32'(NUM_REGS * 4));

    // Ready depends only on registered occupancy, never on rsp_ready.
    assign icb.icb_cmd_ready = (count_q != 2'd2);
    assign icb.icb_rsp_valid = (count_q != 2'd0);
    assign icb.icb_rsp_rdata = buf_data_q[head_q];
    assign icb.icb_rsp_err   = buf_err_q[head_q];

    assign accept = icb.icb_cmd_valid & icb.icb_cmd_ready;
    assign pop    = icb.icb_rsp_valid & icb.icb_rsp_ready;

    always_comb begin
        sel    = '0;
        rd_val = '0;
        if (idx == 6'd0) begin
            rd_val = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == 6'(i)) begin
                sel[i] = 1'b1;
                rd_val = regs_q[i];
            end
        end
    end

    assign wr_ok      = hit & ~icb.icb_cmd_read & (idx != 6'd0);
    assign rsp_err_d  = ~hit | (~icb.icb_cmd_read & (idx == 6'd0));
    assign rsp_data_d = (hit & icb.icb_cmd_read) ? rd_val : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (accept && wr_ok) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[i] && icb.icb_cmd_wmask[b]) begin
                        regs_q[i][8*b +: 8] <= icb.icb_cmd_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // sel[0] is never set, so register 0 never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= (accept && wr_ok) ? sel : '0;
        end
    end

    always_comb begin
        regs_o        = '0;
        regs_o[31:0]  = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs_q[i];
        end
    end

    // Response FIFO: push at tail on accept, pop at head on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_err_q[0]  <= 1'b0;
            buf_err_q[1]  <= 1'b0;
        end else begin
            if (accept) begin
                buf_data_q[tail_q] <= rsp_data_d;
                buf_err_q[tail_q]  <= rsp_err_d;
                tail_q             <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
